// File: rtl/calc_pkg.sv
// Shared encodings for the BCD calculator operand-entry path:
// entry-state codes, digit-select patterns and the BCD digit increment.
package calc_pkg;

   typedef enum logic [2:0] {
      S_A_HI = 3'd0,
      S_A_LO = 3'd1,
      S_B_HI = 3'd2,
      S_B_LO = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [3:0] DSEL_A_HI = 4'b1000;
   localparam logic [3:0] DSEL_A_LO = 4'b0100;
   localparam logic [3:0] DSEL_B_HI = 4'b0010;
   localparam logic [3:0] DSEL_B_LO = 4'b0001;
   localparam logic [3:0] DSEL_DONE = 4'b0000;

   function automatic logic [3:0] dsel_of(input state_t s);
      logic [3:0] d;
      case (s)
         S_A_HI:  d = DSEL_A_HI;
         S_A_LO:  d = DSEL_A_LO;
         S_B_HI:  d = DSEL_B_HI;
         S_B_LO:  d = DSEL_B_LO;
         default: d = DSEL_DONE;
      endcase
      return d;
   endfunction

   // Anything at or above 9 wraps to 0, so a digit can never leave 0..9.
   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_operand_entry_debounce.sv
// One push-button channel: 2-FF synchronizer, stability counter and a
// registered single-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
   parameter int DB_CYCLES = 40000,
   parameter int DB_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// Operand-entry front end: four debounced buttons drive a digit-walk FSM
// that builds two packed-BCD operands plus the add/sub select.
module bcd_operand_entry
   import calc_pkg::*;
#(
   parameter int DB_CYCLES = 40000,
   parameter int DB_W      = 16,
   parameter int BLINK_BIT = 23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_inc,
   input  logic       btn_next,
   input  logic       btn_op,
   input  logic       btn_clr,
   output logic [7:0] num1,
   output logic [7:0] num2,
   output logic       sel,
   output logic       ready,
   output logic [3:0] digit_sel,
   output logic       blink
);

   logic inc_p, next_p, op_p, clr_p;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_inc (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .press(inc_p));
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_next (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .press(next_p));
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_op (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_op), .press(op_p));
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_clr), .press(clr_p));

   state_t         state_q, state_d;
   logic [7:0]     num1_q, num1_d;
   logic [7:0]     num2_q, num2_d;
   logic           sel_q, sel_d;
   logic           ready_q, ready_d;
   logic [3:0]     digit_sel_q, digit_sel_d;
   logic [BLINK_BIT:0] blink_cnt_q, blink_cnt_d;

   // clr outranks next, next outranks inc; op toggles independently of all three.
   always_comb begin
      state_d     = state_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      sel_d       = op_p ? ~sel_q : sel_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (clr_p) begin
         state_d = S_A_HI;
         num1_d  = 8'h00;
         num2_d  = 8'h00;
      end else if (next_p) begin
         case (state_q)
            S_A_HI:  state_d = S_A_LO;
            S_A_LO:  state_d = S_B_HI;
            S_B_HI:  state_d = S_B_LO;
            S_B_LO:  state_d = S_DONE;
            default: state_d = S_A_HI;
         endcase
      end else if (inc_p) begin
         case (state_q)
            S_A_HI:  num1_d[7:4] = bcd_inc(num1_q[7:4]);
            S_A_LO:  num1_d[3:0] = bcd_inc(num1_q[3:0]);
            S_B_HI:  num2_d[7:4] = bcd_inc(num2_q[7:4]);
            S_B_LO:  num2_d[3:0] = bcd_inc(num2_q[3:0]);
            default: ;
         endcase
      end
      ready_d     = (state_d == S_DONE);
      digit_sel_d = dsel_of(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_A_HI;
         num1_q      <= 8'h00;
         num2_q      <= 8'h00;
         sel_q       <= 1'b1;
         ready_q     <= 1'b0;
         digit_sel_q <= DSEL_A_HI;
         blink_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
         sel_q       <= sel_d;
         ready_q     <= ready_d;
         digit_sel_q <= digit_sel_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign num1      = num1_q;
   assign num2      = num2_q;
   assign sel       = sel_q;
   assign ready     = ready_q;
   assign digit_sel = digit_sel_q;
   assign blink     = blink_cnt_q[BLINK_BIT];

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry with a short debounce window: table of button
// presses with expected outputs, plus hand sequences for glitch, combo and reset.
module tb_bcd_operand_entry;
   localparam int DB = 4;
   localparam int W  = 22;

   localparam logic [1:0] B_INC  = 2'd0;
   localparam logic [1:0] B_NEXT = 2'd1;
   localparam logic [1:0] B_OP   = 2'd2;
   localparam logic [1:0] B_CLR  = 2'd3;

   // ---- clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       btn_inc = 1'b0, btn_next = 1'b0, btn_op = 1'b0, btn_clr = 1'b0;
   logic [7:0] num1, num2;
   logic       sel, ready, blink;
   logic [3:0] digit_sel;

   bcd_operand_entry #(.DB_CYCLES(DB), .DB_W(16), .BLINK_BIT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_inc(btn_inc), .btn_next(btn_next), .btn_op(btn_op), .btn_clr(btn_clr),
      .num1(num1), .num2(num2), .sel(sel), .ready(ready),
      .digit_sel(digit_sel), .blink(blink));

   // ---- scoreboard
   logic [W-1:0] exp_q[$];
   int n_vec  = 0;
   int n_miss = 0;

   function automatic logic [W-1:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic s, input logic r, input logic [3:0] d);
      return {a, b, s, r, d};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: expected queue empty", name);
      end else begin
         e = exp_q.pop_front();
         check(name, {num1, num2, sel, ready, digit_sel}, e);
      end
   endtask

   // ---- driver tasks
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input logic [1:0] b, input logic v);
      case (b)
         B_INC:   btn_inc  = v;
         B_NEXT:  btn_next = v;
         B_OP:    btn_op   = v;
         default: btn_clr  = v;
      endcase
   endtask

   task automatic press(input logic [1:0] b);
      set_btn(b, 1'b1);
      wait_cyc(DB + 4);
      set_btn(b, 1'b0);
      wait_cyc(DB + 4);
   endtask

   typedef struct {
      logic [1:0]   btn;
      int           reps;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl[14];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{B_INC,  3,  pk(8'h30, 8'h00, 1'b1, 1'b0, 4'b1000)};
      tbl[1]  = '{B_NEXT, 1,  pk(8'h30, 8'h00, 1'b1, 1'b0, 4'b0100)};
      tbl[2]  = '{B_INC,  7,  pk(8'h37, 8'h00, 1'b1, 1'b0, 4'b0100)};
      tbl[3]  = '{B_NEXT, 1,  pk(8'h37, 8'h00, 1'b1, 1'b0, 4'b0010)};
      tbl[4]  = '{B_INC,  1,  pk(8'h37, 8'h10, 1'b1, 1'b0, 4'b0010)};
      tbl[5]  = '{B_NEXT, 1,  pk(8'h37, 8'h10, 1'b1, 1'b0, 4'b0001)};
      tbl[6]  = '{B_INC,  12, pk(8'h37, 8'h12, 1'b1, 1'b0, 4'b0001)};
      tbl[7]  = '{B_NEXT, 1,  pk(8'h37, 8'h12, 1'b1, 1'b1, 4'b0000)};
      tbl[8]  = '{B_INC,  2,  pk(8'h37, 8'h12, 1'b1, 1'b1, 4'b0000)};
      tbl[9]  = '{B_OP,   1,  pk(8'h37, 8'h12, 1'b0, 1'b1, 4'b0000)};
      tbl[10] = '{B_NEXT, 1,  pk(8'h37, 8'h12, 1'b0, 1'b0, 4'b1000)};
      tbl[11] = '{B_INC,  1,  pk(8'h47, 8'h12, 1'b0, 1'b0, 4'b1000)};
      tbl[12] = '{B_OP,   1,  pk(8'h47, 8'h12, 1'b1, 1'b0, 4'b1000)};
      tbl[13] = '{B_CLR,  1,  pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000)};

      // reset state
      wait_cyc(2);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("reset");
      check("reset_blink", W'(blink), W'(0));
      rst_n = 1'b1;
      wait_cyc(DB + 4);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("idle");

      // table-driven entry walk
      for (int i = 0; i < 14; i++) begin
         for (int r = 0; r < tbl[i].reps; r++) press(tbl[i].btn);
         exp_q.push_back(tbl[i].exp);
         pop_check($sformatf("tbl%0d", i));
      end

      // glitch shorter than the window: no effect
      btn_inc = 1'b1;
      wait_cyc(DB - 1);
      btn_inc = 1'b0;
      wait_cyc(DB + 6);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("glitch");

      // held press: single increment exactly DB+3 edges after the raw edge
      btn_inc = 1'b1;
      wait_cyc(DB + 2);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("hold_before");
      wait_cyc(1);
      exp_q.push_back(pk(8'h10, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("hold_edge");
      wait_cyc(12);
      exp_q.push_back(pk(8'h10, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("hold_norepeat");
      btn_inc = 1'b0;
      wait_cyc(DB + 4);

      // move to A units and bump it, then clr+next+op together
      press(B_NEXT);
      press(B_INC);
      exp_q.push_back(pk(8'h11, 8'h00, 1'b1, 1'b0, 4'b0100));
      pop_check("pre_combo");
      btn_clr = 1'b1; btn_next = 1'b1; btn_op = 1'b1;
      wait_cyc(DB + 4);
      btn_clr = 1'b0; btn_next = 1'b0; btn_op = 1'b0;
      wait_cyc(DB + 4);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b0, 1'b0, 4'b1000));
      pop_check("combo");

      // a next press then inc so the reset has something to clear
      press(B_NEXT);
      press(B_INC);
      exp_q.push_back(pk(8'h01, 8'h00, 1'b0, 1'b0, 4'b0100));
      pop_check("pre_reset");

      // reset mid-debounce with inc held through release
      btn_inc = 1'b1;
      wait_cyc(3);
      rst_n = 1'b0;
      #1;
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("midreset");
      check("midreset_blink", W'(blink), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(DB + 2);
      exp_q.push_back(pk(8'h00, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("rst_hold_before");
      wait_cyc(1);
      exp_q.push_back(pk(8'h10, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("rst_hold_inc");
      check("blink_lo", W'(blink), W'(0));
      wait_cyc(1);
      check("blink_hi", W'(blink), W'(1));
      btn_inc = 1'b0;
      wait_cyc(DB + 4);
      exp_q.push_back(pk(8'h10, 8'h00, 1'b1, 1'b0, 4'b1000));
      pop_check("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
